eth_frame_echo: RTL

Parametrised Ethernet payload echo engine sitting between the MAC receive FIFO and the MAC transmit FIFO. It drains one received payload into an internal byte buffer, detects end-of-frame by an idle gap, then replays the payload to the transmit side, padding short payloads up to the minimum Ethernet payload size. It adds configurable depth, gap, padding and statistics. An optional byte mirror feeds the UART debug path.

---
 rtl/eth_echo_pkg.sv | 19 +
 rtl/echo_frame_ram.sv | 17 +
 rtl/eth_frame_echo.sv | 123 ++++++++++++
 3 files changed

// File: rtl/eth_echo_pkg.sv
// eth_echo_pkg: shared state encoding and defaults for the Ethernet payload echo engine.
package eth_echo_pkg;
    localparam int ETH_MIN_PAYLOAD = 46;
    localparam int ETH_GAP_CYCLES = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_READ = 3'd1;
    localparam logic [2:0] ST_READ_GAP = 3'd2;
    localparam logic [2:0] ST_TX_PREP = 3'd3;
    localparam logic [2:0] ST_TX = 3'd4;
    localparam logic [2:0] ST_TX_GAP = 3'd5;
    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_READ = ST_READ,
        S_READ_GAP = ST_READ_GAP,
        S_TX_PREP = ST_TX_PREP,
        S_TX = ST_TX,
        S_TX_GAP = ST_TX_GAP
    } state_t;
endpackage

// File: rtl/echo_frame_ram.sv
// echo_frame_ram: single-clock simple dual-port byte RAM with a synchronous read port.
module echo_frame_ram #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  logic [7:0]            i_wdata,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output logic [7:0]            o_rdata
);
    logic [7:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        o_rdata <= mem[i_raddr];
    end
endmodule

// File: rtl/eth_frame_echo.sv
// eth_frame_echo: buffers one RX payload, detects end-of-frame by an idle gap, replays it padded.
// Define ETH_ECHO_UART_MIRROR_EN to mirror the TX byte stream onto o_wvalid_u/o_wdata_u.
module eth_frame_echo
    import eth_echo_pkg::*;
#(
    parameter int         DEPTH_LOG2  = 10,
    parameter int         MIN_PAYLOAD = ETH_MIN_PAYLOAD,
    parameter int         GAP_CYCLES  = ETH_GAP_CYCLES,
    parameter logic [7:0] PAD_BYTE    = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [7:0]  i_rdata,
    input  logic        i_rready,
    output logic        o_rreq,
    input  logic        i_wready,
    output logic        o_wvalid,
    output logic [7:0]  o_wdata,
    output logic        o_wvalid_u,
    output logic [7:0]  o_wdata_u,
    output logic        o_done,
    output logic        o_busy,
    output logic        o_ovf,
    output logic [15:0] o_frame_cnt
);
    localparam int AW = DEPTH_LOG2 + 1;
    localparam int MW = $clog2(MIN_PAYLOAD + 1);
    localparam int SW = AW > MW ? AW : MW;
    localparam int GW = $clog2(GAP_CYCLES) + 1;

    state_t        state;
    logic [AW-1:0] load_addr;
    logic [SW-1:0] send_addr, tx_len, len_ext;
    logic [GW-1:0] gap_cnt;
    logic [7:0]    rd_data;
    logic          we;

    assign len_ext = SW'(load_addr);
    assign we = state == S_READ && !load_addr[DEPTH_LOG2];
    assign o_rreq = !i_rst && i_rready && (state == S_IDLE || state == S_READ_GAP);
    assign o_busy = state != S_IDLE;

    // send_addr is presented a cycle early; TX_PREP/TX_GAP cover the read latency
    echo_frame_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .i_clk  (i_clk),
        .i_we   (we),
        .i_waddr(load_addr[DEPTH_LOG2-1:0]),
        .i_wdata(i_rdata),
        .i_raddr(send_addr[DEPTH_LOG2-1:0]),
        .o_rdata(rd_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            load_addr   <= '0;
            send_addr   <= '0;
            tx_len      <= '0;
            gap_cnt     <= '0;
            o_wvalid    <= 1'b0;
            o_wdata     <= '0;
            o_done      <= 1'b0;
            o_ovf       <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            o_wvalid <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    load_addr <= '0;
                    send_addr <= '0;
                    gap_cnt   <= '0;
                    if (i_rready) state <= S_READ;
                end
                S_READ: begin
                    if (load_addr[DEPTH_LOG2]) o_ovf <= 1'b1;
                    else load_addr <= load_addr + 1'b1;
                    gap_cnt <= '0;
                    state   <= S_READ_GAP;
                end
                S_READ_GAP: begin
                    if (i_rready) state <= S_READ;
                    else begin
                        gap_cnt <= gap_cnt + 1'b1;
                        if (gap_cnt == GW'(GAP_CYCLES - 1)) state <= S_TX_PREP;
                    end
                end
                S_TX_PREP: begin
                    if (!i_en || load_addr == '0) state <= S_IDLE;
                    else begin
                        tx_len <= len_ext > SW'(MIN_PAYLOAD) ? len_ext : SW'(MIN_PAYLOAD);
                        state  <= S_TX;
                    end
                end
                S_TX: begin
                    if (i_wready) begin
                        o_wvalid  <= 1'b1;
                        o_wdata   <= send_addr >= len_ext ? PAD_BYTE : rd_data;
                        send_addr <= send_addr + 1'b1;
                        state     <= S_TX_GAP;
                    end
                end
                S_TX_GAP: begin
                    if (send_addr == tx_len) begin
                        o_done      <= 1'b1;
                        o_frame_cnt <= o_frame_cnt + 1'b1;
                        state       <= S_IDLE;
                    end else state <= S_TX;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ETH_ECHO_UART_MIRROR_EN
    assign o_wvalid_u = o_wvalid;
    assign o_wdata_u  = o_wdata;
`else
    assign o_wvalid_u = 1'b0;
    assign o_wdata_u  = 8'h00;
`endif
endmodule
